// File: rtl/sfp_define_pkg.sv
// Shared SFP link definitions: control-word constants, lock FSM encodings and
// the marker-pair kinds used by the encoder, decoder and link monitor.
package sfp_define_pkg;

    localparam logic [31:0] SFP_VS_POSE_DATA1 = 32'h55a101bc;
    localparam logic [31:0] SFP_VS_POSE_DATA2 = 32'h55a102bc;
    localparam logic [31:0] SFP_DATA_START1   = 32'h55a105bc;
    localparam logic [31:0] SFP_DATA_START2   = 32'h55a106bc;
    localparam logic [31:0] SFP_DATA_END1     = 32'h55a107bc;
    localparam logic [31:0] SFP_DATA_END2     = 32'h55a108bc;
    localparam logic [31:0] SFP_UNUSE_DATA    = 32'h55a109bc;

    localparam logic [3:0]  SFP_K_CTRL        = 4'b0001;
    localparam logic [3:0]  SFP_K_DATA        = 4'b0000;

    localparam logic [1:0]  ST_DOWN           = 2'd0;
    localparam logic [1:0]  ST_SYNC           = 2'd1;
    localparam logic [1:0]  ST_UP             = 2'd2;

    typedef enum logic [1:0] {
        PAIR_START = 2'd0,
        PAIR_END   = 2'd1,
        PAIR_VS    = 2'd2
    } pair_e;

endpackage

// File: rtl/sfp_err_window.sv
// Error-density window: counts words and errors while the link is up and
// raises drop when the error that would reach the limit arrives.
module sfp_err_window #(
    parameter int unsigned ERR_WINDOW = 1024,
    parameter int unsigned ERR_LIMIT  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic err,
    output logic drop
);
    localparam int unsigned WW = $clog2(ERR_WINDOW);
    localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

    logic [WW-1:0] win_cnt_r;
    logic [EW-1:0] win_err_r;
    logic          wrap_s;

    assign wrap_s = (win_cnt_r == WW'(ERR_WINDOW - 1));
    assign drop   = en & err & (win_err_r == EW'(ERR_LIMIT - 1));

    // Window counters; an error on the wrap word opens the new window at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r <= '0;
            win_err_r <= '0;
        end else if (!en) begin
            win_cnt_r <= '0;
            win_err_r <= '0;
        end else begin
            win_cnt_r <= win_cnt_r + WW'(1);
            win_err_r <= wrap_s ? EW'(err) : (win_err_r + EW'(err));
        end
    end

endmodule

// File: rtl/sfp_rx_link_monitor.sv
// Lane-1 receive link monitor: classifies aligned words, tracks lock, checks
// marker framing and keeps debug counters on the rx1 user clock.
module sfp_rx_link_monitor
    import sfp_define_pkg::*;
#(
    parameter logic [31:0] VS_POSE_DATA1 = SFP_VS_POSE_DATA1,
    parameter logic [31:0] VS_POSE_DATA2 = SFP_VS_POSE_DATA2,
    parameter logic [31:0] DATA_START1   = SFP_DATA_START1,
    parameter logic [31:0] DATA_START2   = SFP_DATA_START2,
    parameter logic [31:0] DATA_END1     = SFP_DATA_END1,
    parameter logic [31:0] DATA_END2     = SFP_DATA_END2,
    parameter logic [31:0] UNUSE_DATA    = SFP_UNUSE_DATA,
    parameter int unsigned LOCK_CNT      = 64,
    parameter int unsigned ERR_WINDOW    = 1024,
    parameter int unsigned ERR_LIMIT     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data_in,
    input  logic [3:0]  rx_charisk_in,
    output logic        link_up,
    output logic        word_err,
    output logic        frame_err,
    output logic [15:0] err_cnt,
    output logic [15:0] frame_cnt,
    output logic [1:0]  state_o
);
    localparam int unsigned GW = $clog2(LOCK_CNT);

    logic          is_k_s, is_data_s, valid_s;
    logic          is_vs1_s, is_vs2_s, is_start1_s, is_start2_s;
    logic          is_end1_s, is_end2_s, is_idle_s;
    logic          frame_viol_s, line_done_s, err_s, drop_s;
    logic          in_line_nxt_s, exp2_nxt_s;
    pair_e         pair_nxt_s;
    logic [1:0]    state_nxt_s;
    logic [GW-1:0] good_nxt_s;

    logic [1:0]    state_r;
    logic [GW-1:0] good_r;
    logic          in_line_r, exp2_r;
    pair_e         pair_r;

    assign is_k_s      = (rx_charisk_in == SFP_K_CTRL);
    assign is_data_s   = (rx_charisk_in == SFP_K_DATA);
    assign is_vs1_s    = is_k_s & (rx_data_in == VS_POSE_DATA1);
    assign is_vs2_s    = is_k_s & (rx_data_in == VS_POSE_DATA2);
    assign is_start1_s = is_k_s & (rx_data_in == DATA_START1);
    assign is_start2_s = is_k_s & (rx_data_in == DATA_START2);
    assign is_end1_s   = is_k_s & (rx_data_in == DATA_END1);
    assign is_end2_s   = is_k_s & (rx_data_in == DATA_END2);
    assign is_idle_s   = is_k_s & (rx_data_in == UNUSE_DATA);
    assign valid_s     = is_data_s | is_vs1_s | is_vs2_s | is_start1_s
                       | is_start2_s | is_end1_s | is_end2_s | is_idle_s;
    // Framing is never blamed for an invalid word, so the two never overlap.
    assign err_s       = ~valid_s | frame_viol_s;

    sfp_err_window #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_err_window (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == ST_UP),
        .err   (err_s),
        .drop  (drop_s)
    );

    // Marker-pair framing checker, active only on valid words while UP.
    always_comb begin
        frame_viol_s  = 1'b0;
        line_done_s   = 1'b0;
        in_line_nxt_s = in_line_r;
        exp2_nxt_s    = exp2_r;
        pair_nxt_s    = pair_r;
        if ((state_r == ST_UP) && valid_s) begin
            if (exp2_r) begin
                exp2_nxt_s = 1'b0;
                case (pair_r)
                    PAIR_START: begin
                        frame_viol_s  = ~is_start2_s;
                        in_line_nxt_s = is_start2_s;
                    end
                    PAIR_END: begin
                        frame_viol_s  = ~is_end2_s;
                        line_done_s   = is_end2_s;
                        in_line_nxt_s = 1'b0;
                    end
                    PAIR_VS: begin
                        frame_viol_s  = ~is_vs2_s;
                    end
                    default: begin
                        frame_viol_s  = 1'b1;
                    end
                endcase
            end else if (is_data_s) begin
                frame_viol_s = ~in_line_r;
            end else if (is_start1_s | is_vs1_s) begin
                if (in_line_r) begin
                    frame_viol_s = 1'b1;
                end else begin
                    exp2_nxt_s = 1'b1;
                    pair_nxt_s = is_start1_s ? PAIR_START : PAIR_VS;
                end
            end else if (is_end1_s) begin
                if (in_line_r) begin
                    exp2_nxt_s = 1'b1;
                    pair_nxt_s = PAIR_END;
                end else begin
                    frame_viol_s = 1'b1;
                end
            end else begin
                // Only idle is left as legal; a lone second word is an orphan.
                frame_viol_s = ~is_idle_s;
            end
            if (frame_viol_s) begin
                in_line_nxt_s = 1'b0;
                exp2_nxt_s    = 1'b0;
            end else begin
                in_line_nxt_s = in_line_nxt_s;
            end
        end else begin
            in_line_nxt_s = 1'b0;
            exp2_nxt_s    = 1'b0;
        end
    end

    // Lock FSM: idle enters SYNC, LOCK_CNT clean words reach UP, error density drops it.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_r;
        case (state_r)
            ST_DOWN: begin
                if (is_idle_s) begin
                    state_nxt_s = ST_SYNC;
                    good_nxt_s  = GW'(1);
                end else begin
                    good_nxt_s  = '0;
                end
            end
            ST_SYNC: begin
                if (!valid_s) begin
                    state_nxt_s = ST_DOWN;
                    good_nxt_s  = '0;
                end else if (good_r == GW'(LOCK_CNT - 1)) begin
                    state_nxt_s = ST_UP;
                    good_nxt_s  = '0;
                end else begin
                    good_nxt_s  = good_r + GW'(1);
                end
            end
            ST_UP: begin
                if (drop_s) begin
                    state_nxt_s = ST_DOWN;
                end else begin
                    state_nxt_s = ST_UP;
                end
            end
            default: begin
                state_nxt_s = ST_DOWN;
                good_nxt_s  = '0;
            end
        endcase
    end

    // State, framing flags and all registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_DOWN;
            good_r    <= '0;
            in_line_r <= 1'b0;
            exp2_r    <= 1'b0;
            pair_r    <= PAIR_START;
            link_up   <= 1'b0;
            word_err  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 16'h0000;
            frame_cnt <= 16'h0000;
            state_o   <= ST_DOWN;
        end else begin
            state_r   <= state_nxt_s;
            good_r    <= good_nxt_s;
            pair_r    <= pair_nxt_s;
            if (drop_s) begin
                in_line_r <= 1'b0;
                exp2_r    <= 1'b0;
            end else begin
                in_line_r <= in_line_nxt_s;
                exp2_r    <= exp2_nxt_s;
            end
            link_up   <= (state_nxt_s == ST_UP);
            state_o   <= state_nxt_s;
            word_err  <= ~valid_s;
            frame_err <= frame_viol_s;
            if (err_s && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (line_done_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sfp_rx_link_monitor.sv
// Directed bench for sfp_rx_link_monitor: a word-level behavioural model is
// compared against every output each cycle, plus hand-computed checkpoints.
module tb_sfp_rx_link_monitor;

    localparam logic [31:0] VS1    = 32'h55a101bc;
    localparam logic [31:0] VS2    = 32'h55a102bc;
    localparam logic [31:0] START1 = 32'h55a105bc;
    localparam logic [31:0] START2 = 32'h55a106bc;
    localparam logic [31:0] END1   = 32'h55a107bc;
    localparam logic [31:0] END2   = 32'h55a108bc;
    localparam logic [31:0] IDLE   = 32'h55a109bc;
    localparam int LOCK   = 64;
    localparam int WIN    = 1024;
    localparam int LIMIT  = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] rx_data;
    logic [3:0]  rx_k;
    logic        link_up, word_err, frame_err;
    logic [15:0] err_cnt, frame_cnt;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    sfp_rx_link_monitor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data_in    (rx_data),
        .rx_charisk_in (rx_k),
        .link_up       (link_up),
        .word_err      (word_err),
        .frame_err     (frame_err),
        .err_cnt       (err_cnt),
        .frame_cnt     (frame_cnt),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: st 0/1/2, words seen since lock, errors in current window,
    // the marker word owed next (0 = none), and expected outputs.
    typedef struct packed {
        int          st;
        int          good;
        int          n;
        int          werr;
        logic [31:0] due;
        bit          line;
        int          errc;
        int          fcnt;
        bit          we;
        bit          fe;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic [31:0] d, logic [3:0] k);
        model_t r;
        bit ctrl, valid, err, drop;
        r = c;
        ctrl  = (k == 4'b0001) && (d == VS1 || d == VS2 || d == START1 || d == START2 ||
                                   d == END1 || d == END2 || d == IDLE);
        valid = ctrl || (k == 4'b0000);
        r.we = !valid;
        r.fe = 1'b0;
        if (c.st == 2 && valid) begin
            if (c.due != 32'h0) begin
                if (ctrl && d == c.due) begin
                    if (d == START2) r.line = 1'b1;
                    if (d == END2) begin
                        r.line = 1'b0;
                        r.fcnt = (c.fcnt + 1) % 65536;
                    end
                    r.due = 32'h0;
                end else begin
                    r.fe = 1'b1;
                end
            end else if (!ctrl) begin
                r.fe = !c.line;
            end else if (d == START1 || d == VS1) begin
                if (c.line) r.fe = 1'b1;
                else r.due = d + 32'h100;  // second word of each pair is first + 0x100
            end else if (d == END1) begin
                if (c.line) r.due = END2;
                else r.fe = 1'b1;
            end else if (d != IDLE) begin
                r.fe = 1'b1;
            end
            if (r.fe) begin
                r.line = 1'b0;
                r.due  = 32'h0;
            end
        end else begin
            r.line = 1'b0;
            r.due  = 32'h0;
        end
        err = r.we || r.fe;
        if (err && r.errc < 65535) r.errc = r.errc + 1;
        case (c.st)
            0: if (ctrl && d == IDLE) begin r.st = 1; r.good = 1; end
            1: begin
                if (!valid) begin
                    r.st = 0; r.good = 0;
                end else if (c.good + 1 == LOCK) begin
                    r.st = 2; r.n = 0; r.werr = 0;
                end else begin
                    r.good = c.good + 1;
                end
            end
            default: begin
                drop = err && (c.werr == LIMIT - 1);
                r.werr = ((c.n % WIN) == WIN - 1) ? int'(err) : c.werr + int'(err);
                r.n = c.n + 1;
                if (drop) begin
                    r.st = 0; r.good = 0; r.line = 1'b0; r.due = 32'h0;
                end
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, rx_data, rx_k);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("link_up",   32'(link_up),   32'(m.st == 2));
            check("state_o",   32'(state_o),   32'(m.st));
            check("word_err",  32'(word_err),  32'(m.we));
            check("frame_err", 32'(frame_err), 32'(m.fe));
            check("err_cnt",   32'(err_cnt),   32'(m.errc));
            check("frame_cnt", 32'(frame_cnt), 32'(m.fcnt));
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        rx_data = d;
        rx_k    = k;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) send(IDLE, 4'b0001);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        rx_data = 32'h0;
        rx_k    = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_data = 32'h0;
        rx_k    = 4'b0000;

        // Reset state and lock acquisition
        do_reset();
        settle();
        check("reset link_up", 32'(link_up), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        idles(63);
        settle();
        check("63 idles state", 32'(state_o), 32'd1);
        check("63 idles link",  32'(link_up), 32'd0);
        idles(1);
        settle();
        check("64 idles link",  32'(link_up), 32'd1);
        check("64 idles state", 32'(state_o), 32'd2);

        // One complete line, preceded by a vsync pair
        send(VS1, 4'b0001);
        send(VS2, 4'b0001);
        send(START1, 4'b0001);
        send(START2, 4'b0001);
        for (int i = 0; i < 10; i++) send(32'hA000_0000 + 32'(i), 4'b0000);
        send(END1, 4'b0001);
        send(END2, 4'b0001);
        settle();
        check("line frame_cnt", 32'(frame_cnt), 32'd1);
        check("line err_cnt",   32'(err_cnt),   32'd0);

        // Stray data, missing second word, orphan END2
        send(32'h12345678, 4'b0000);
        settle();
        check("stray frame_err", 32'(frame_err), 32'd1);
        check("stray err_cnt",   32'(err_cnt),   32'd1);
        check("stray link_up",   32'(link_up),   32'd1);
        send(IDLE, 4'b0001);
        settle();
        check("pulse ends", 32'(frame_err), 32'd0);
        send(START1, 4'b0001);
        send(IDLE, 4'b0001);
        settle();
        check("missing START2", 32'(frame_err), 32'd1);
        send(END2, 4'b0001);
        settle();
        check("orphan END2 err_cnt", 32'(err_cnt), 32'd3);

        // Eight invalid words in one window drop the link
        do_reset();
        idles(LOCK);
        for (int i = 0; i < 8; i++) begin
            idles(2);
            send(IDLE, 4'b0011);
            if (i == 6) begin
                settle();
                check("7 errs link_up", 32'(link_up), 32'd1);
            end
        end
        settle();
        check("8 errs link_up",   32'(link_up),   32'd0);
        check("8 errs err_cnt",   32'(err_cnt),   32'd8);
        check("8 errs word_err",  32'(word_err),  32'd1);
        check("8 errs frame_err", 32'(frame_err), 32'd0);

        // Seven errors before the wrap and seven after keep the link up
        do_reset();
        idles(LOCK);
        idles(1000);
        for (int i = 0; i < 7; i++) send(IDLE, 4'b0011);
        idles(17);
        for (int i = 0; i < 7; i++) begin
            send(IDLE, 4'b0011);
            send(IDLE, 4'b0001);
        end
        settle();
        check("window wrap link_up", 32'(link_up), 32'd1);
        check("window wrap err_cnt", 32'(err_cnt), 32'd14);
        send(IDLE, 4'b0011);
        settle();
        check("8th in new window link_up", 32'(link_up), 32'd0);
        check("8th in new window err_cnt", 32'(err_cnt), 32'd15);

        // Asynchronous reset mid-line, then a fresh relock
        do_reset();
        idles(LOCK);
        for (int i = 0; i < 5; i++) send(32'hDEAD_BEEF, 4'b1000);
        send(START1, 4'b0001);
        send(START2, 4'b0001);
        for (int i = 0; i < 3; i++) send(32'h0000_1111 * 32'(i + 1), 4'b0000);
        settle();
        check("pre-reset err_cnt", 32'(err_cnt), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("async link_up",   32'(link_up),   32'd0);
        check("async word_err",  32'(word_err),  32'd0);
        check("async frame_err", 32'(frame_err), 32'd0);
        check("async err_cnt",   32'(err_cnt),   32'd0);
        check("async frame_cnt", 32'(frame_cnt), 32'd0);
        check("async state_o",   32'(state_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idles(63);
        settle();
        check("relock 63 link_up", 32'(link_up), 32'd0);
        idles(1);
        settle();
        check("relock 64 link_up", 32'(link_up), 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
